// File: rtl/tx_frame_buf_ring.sv
// Transmit frame buffer: a ring of NUM_SLOTS frame slots in one RAM, written by a
// producer slot-by-slot and drained in order by a read FSM. Optional macro: TX_BUF_PARITY_EN.
module tx_frame_buf_ring #(
  parameter int DATA_W     = 32,
  parameter int SLOT_DEPTH = 256,
  parameter int NUM_SLOTS  = 4,
  localparam int AW = $clog2(SLOT_DEPTH),
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int LW = $clog2(SLOT_DEPTH*DATA_W/8) + 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic [LW-1:0]     wr_len,
  output logic              wr_full,
  output logic [SW-1:0]     wr_slot,
  output logic              wr_err,
  output logic              frame_avail,
  output logic [LW-1:0]     frame_len,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dv,
  output logic              rd_last,
`ifdef TX_BUF_PARITY_EN
  output logic              rd_par_err,
`endif
  input  logic              rd_done
);

  localparam int BPW    = DATA_W / 8;
  localparam int BSH    = $clog2(BPW);
  localparam int MAXLEN = SLOT_DEPTH * BPW;
  localparam int DEPTH  = NUM_SLOTS * SLOT_DEPTH;
`ifdef TX_BUF_PARITY_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_t;

  logic [RW-1:0]     mem_r [DEPTH];
  logic [LW-1:0]     len_r [NUM_SLOTS];
  logic [SW-1:0]     wp_r;
  logic [SW-1:0]     rp_r;
  logic [SW:0]       cnt_r;
  logic [AW-1:0]     wcnt_r;
  rd_state_t         state_r;
  logic              wr_err_r;
  logic              rd_dv_r;
  logic              rd_last_r;
  logic [DATA_W-1:0] rd_data_r;

  logic              full_s;
  logic              len_bad_s;
  logic              commit_ok_s;
  logic              commit_rej_s;
  logic              done_ok_s;
  logic              wr_fire_s;
  logic              rd_fire_s;
  logic [LW-1:0]     head_len_s;
  logic [LW-1:0]     words_s;
  logic [AW-1:0]     last_idx_s;
  logic [SW+AW-1:0]  wr_ram_addr_s;
  logic [SW+AW-1:0]  rd_ram_addr_s;
  logic [RW-1:0]     wr_word_s;

`ifdef TX_BUF_PARITY_EN
  logic              rd_par_err_r;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic par_bad(input logic [RW-1:0] w);
    return ^w;
  endfunction

  assign wr_word_s  = {even_par(wr_data), wr_data};
  assign rd_par_err = rd_par_err_r;
`else
  assign wr_word_s  = wr_data;
`endif

  assign full_s        = (cnt_r == (SW+1)'(NUM_SLOTS));
  assign len_bad_s     = (wr_len == {LW{1'b0}}) || (wr_len > LW'(MAXLEN));
  assign commit_ok_s   = wr_commit && !full_s && !len_bad_s;
  assign commit_rej_s  = wr_commit && !commit_ok_s;
  assign done_ok_s     = rd_done && (cnt_r != {(SW+1){1'b0}});
  assign wr_fire_s     = wr_en && !full_s;
  // rd_done takes priority over a read issued in the same cycle
  assign rd_fire_s     = (state_r == ST_RD) && rd_en && !done_ok_s;
  assign head_len_s    = len_r[rp_r];
  assign words_s       = (head_len_s + LW'(BPW - 1)) >> BSH;
  assign last_idx_s    = AW'(words_s - LW'(1));
  assign wr_ram_addr_s = {wp_r, wr_addr};
  assign rd_ram_addr_s = {rp_r, wcnt_r};

  assign wr_full     = full_s;
  assign wr_slot     = wp_r;
  assign wr_err      = wr_err_r;
  assign frame_avail = (cnt_r != {(SW+1){1'b0}});
  assign frame_len   = head_len_s;
  assign rd_data     = rd_data_r;
  assign rd_dv       = rd_dv_r;
  assign rd_last     = rd_last_r;

  // Frame RAM write port (contents intentionally not reset)
  always_ff @(posedge hclk) begin
    if (wr_fire_s) begin
      mem_r[wr_ram_addr_s] <= wr_word_s;
    end
  end

  // Ring pointers, occupancy, per-slot lengths and commit error pulse
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wp_r     <= {SW{1'b0}};
      rp_r     <= {SW{1'b0}};
      cnt_r    <= {(SW+1){1'b0}};
      wr_err_r <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        len_r[i] <= {LW{1'b0}};
      end
    end else begin
      wr_err_r <= commit_rej_s;
      if (commit_ok_s) begin
        len_r[wp_r] <= wr_len;
        wp_r        <= wp_r + SW'(1);
      end
      if (done_ok_s) begin
        rp_r <= rp_r + SW'(1);
      end
      case ({commit_ok_s, done_ok_s})
        2'b10:   cnt_r <= cnt_r + (SW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (SW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Read FSM, word counter and registered read outputs
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r   <= ST_IDLE;
      wcnt_r    <= {AW{1'b0}};
      rd_dv_r   <= 1'b0;
      rd_last_r <= 1'b0;
      rd_data_r <= {DATA_W{1'b0}};
`ifdef TX_BUF_PARITY_EN
      rd_par_err_r <= 1'b0;
`endif
    end else begin
      rd_dv_r   <= rd_fire_s;
      rd_last_r <= rd_fire_s && (wcnt_r == last_idx_s);
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_ram_addr_s][DATA_W-1:0];
      end
`ifdef TX_BUF_PARITY_EN
      rd_par_err_r <= rd_fire_s && par_bad(mem_r[rd_ram_addr_s]);
`endif
      if (done_ok_s) begin
        state_r <= ST_IDLE;
        wcnt_r  <= {AW{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cnt_r != {(SW+1){1'b0}}) begin
              state_r <= ST_RD;
            end
          end
          ST_RD: begin
            if (rd_fire_s) begin
              if (wcnt_r == last_idx_s) begin
                state_r <= ST_WAIT;
              end else begin
                wcnt_r <= wcnt_r + AW'(1);
              end
            end
          end
          ST_WAIT: state_r <= ST_WAIT;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_buf_ring.sv
// Scoreboard bench for tx_frame_buf_ring (default parameters): directed frames are
// pushed as expected words; a negedge monitor pops and compares every rd_dv word.
module tb_tx_frame_buf_ring;

  logic        hclk;
  logic        hresetn;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic [10:0] wr_len;
  logic        wr_full;
  logic [1:0]  wr_slot;
  logic        wr_err;
  logic        frame_avail;
  logic [10:0] frame_len;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_dv;
  logic        rd_last;
  logic        rd_done;
`ifdef TX_BUF_PARITY_EN
  logic        rd_par_err;
  bit          pq[$];
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_w;

  tx_frame_buf_ring dut (
    .hclk(hclk), .hresetn(hresetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_len(wr_len),
    .wr_full(wr_full), .wr_slot(wr_slot), .wr_err(wr_err),
    .frame_avail(frame_avail), .frame_len(frame_len),
    .rd_en(rd_en), .rd_data(rd_data), .rd_dv(rd_dv), .rd_last(rd_last),
`ifdef TX_BUF_PARITY_EN
    .rd_par_err(rd_par_err),
`endif
    .rd_done(rd_done)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented read word must match the head of the scoreboard
  always @(negedge hclk) begin
    if (hresetn && rd_dv) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        exp_w = sb.pop_front();
        check("rd_word", {31'd0, rd_last, rd_data}, {31'd0, exp_w});
`ifdef TX_BUF_PARITY_EN
        check("rd_par_err", {63'd0, rd_par_err}, {63'd0, pq.pop_front()});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = base + 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic commit(input logic [10:0] len);
    wr_commit = 1'b1; wr_len = len;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic expect_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      sb.push_back({(i == n - 1), base + 32'(i)});
`ifdef TX_BUF_PARITY_EN
      pq.push_back(1'b0);
`endif
    end
  endtask

  task automatic read_frame(input bit do_done);
    int k;
    k = 0;
    rd_en = 1'b1;
    while (sb.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    rd_en = 1'b0;
    if (do_done) begin
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    hresetn = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 32'd0;
    wr_commit = 1'b0; wr_len = 11'd0; rd_en = 1'b0; rd_done = 1'b0;
    #1;
    check("rst_wr_full", {63'd0, wr_full}, 64'd0);
    check("rst_wr_slot", {62'd0, wr_slot}, 64'd0);
    check("rst_wr_err", {63'd0, wr_err}, 64'd0);
    check("rst_frame_avail", {63'd0, frame_avail}, 64'd0);
    check("rst_frame_len", {53'd0, frame_len}, 64'd0);
    check("rst_rd_dv", {63'd0, rd_dv}, 64'd0);
    check("rst_rd_last", {63'd0, rd_last}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    tick(); tick();
    hresetn = 1'b1;
    tick();

    // 16-word frame in slot 0
    fill(16, 32'h1000_0000);
    commit(11'd64);
    check("f0_avail", {63'd0, frame_avail}, 64'd1);
    check("f0_len", {53'd0, frame_len}, 64'd64);
    check("f0_wr_slot", {62'd0, wr_slot}, 64'd1);
    expect_frame(16, 32'h1000_0000);
    read_frame(1'b1);
    check("f0_released", {63'd0, frame_avail}, 64'd0);

    // Rejected commits: zero length and oversize
    commit(11'd0);
    check("len0_err", {63'd0, wr_err}, 64'd1);
    check("len0_avail", {63'd0, frame_avail}, 64'd0);
    tick();
    check("len0_err_pulse", {63'd0, wr_err}, 64'd0);
    commit(11'd1025);
    check("len_big_err", {63'd0, wr_err}, 64'd1);
    check("len_big_slot", {62'd0, wr_slot}, 64'd1);
    tick();

    // Partial last word: 9 bytes -> 3 words
    fill(3, 32'h2000_0000);
    commit(11'd9);
    check("f9_len", {53'd0, frame_len}, 64'd9);
    expect_frame(3, 32'h2000_0000);
    read_frame(1'b1);

    // Fill all four slots (2, 3, 0, 1) then overflow
    fill(2, 32'hA200_0000); commit(11'd8);
    fill(2, 32'hA300_0000); commit(11'd8);
    fill(2, 32'hA000_0000); commit(11'd8);
    fill(2, 32'hA100_0000); commit(11'd8);
    check("full_flag", {63'd0, wr_full}, 64'd1);
    check("full_slot", {62'd0, wr_slot}, 64'd2);
    commit(11'd8);
    check("full_commit_err", {63'd0, wr_err}, 64'd1);
    check("full_still", {63'd0, wr_full}, 64'd1);
    check("full_slot_hold", {62'd0, wr_slot}, 64'd2);
    fill(1, 32'hDEAD_BEEF);
    expect_frame(2, 32'hA200_0000);
    read_frame(1'b1);
    check("after_one_read_full", {63'd0, wr_full}, 64'd0);
    expect_frame(2, 32'hA300_0000);
    read_frame(1'b1);

    // cnt=2: read slot 0, then commit slot 2 together with rd_done
    expect_frame(2, 32'hA000_0000);
    read_frame(1'b0);
    fill(4, 32'hB200_0000);
    wr_commit = 1'b1; wr_len = 11'd16; rd_done = 1'b1;
    tick();
    wr_commit = 1'b0; rd_done = 1'b0;
    check("same_cyc_slot", {62'd0, wr_slot}, 64'd3);
    check("same_cyc_avail", {63'd0, frame_avail}, 64'd1);
    check("same_cyc_len", {53'd0, frame_len}, 64'd8);
    fill(2, 32'hB300_0000); commit(11'd8);
    check("cnt3_not_full", {63'd0, wr_full}, 64'd0);
    fill(3, 32'hB000_0000); commit(11'd12);
    check("wrap_full", {63'd0, wr_full}, 64'd1);
    check("wrap_slot", {62'd0, wr_slot}, 64'd1);
    expect_frame(2, 32'hA100_0000); read_frame(1'b1);
    check("b2_len", {53'd0, frame_len}, 64'd16);
    expect_frame(4, 32'hB200_0000); read_frame(1'b1);
    expect_frame(2, 32'hB300_0000); read_frame(1'b1);
    check("b0_len", {53'd0, frame_len}, 64'd12);
    expect_frame(3, 32'hB000_0000); read_frame(1'b1);
    check("ring_empty", {63'd0, frame_avail}, 64'd0);

    // Reset in the middle of a 16-word read
    fill(16, 32'hC000_0000);
    commit(11'd64);
    expect_frame(16, 32'hC000_0000);
    rd_en = 1'b1;
    k = 0;
    while (sb.size() > 11 && k < 400) begin
      tick();
      k++;
    end
    check("mid_rst_reach", 64'(sb.size()), 64'd11);
    hresetn = 1'b0;
    #1;
    check("mid_rst_rd_dv", {63'd0, rd_dv}, 64'd0);
    check("mid_rst_rd_last", {63'd0, rd_last}, 64'd0);
    check("mid_rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("mid_rst_avail", {63'd0, frame_avail}, 64'd0);
    check("mid_rst_slot", {62'd0, wr_slot}, 64'd0);
    check("mid_rst_len", {53'd0, frame_len}, 64'd0);
    sb.delete();
`ifdef TX_BUF_PARITY_EN
    pq.delete();
`endif
    rd_en = 1'b0;
    tick();
    hresetn = 1'b1;
    tick(); tick();
    check("post_rst_avail", {63'd0, frame_avail}, 64'd0);

    // Single-word frame after reset
    fill(1, 32'hE000_0001);
    commit(11'd4);
    expect_frame(1, 32'hE000_0001);
    read_frame(1'b1);

`ifdef TX_BUF_PARITY_EN
    begin
      logic [9:0] idx;
      fill(8, 32'hF000_0000);
      commit(11'd32);
      idx = {2'd1, 8'd3};
      dut.mem_r[idx][5] = ~dut.mem_r[idx][5];
      for (int i = 0; i < 8; i++) begin
        sb.push_back({(i == 7), (32'hF000_0000 + 32'(i)) ^ ((i == 3) ? 32'h20 : 32'h0)});
        pq.push_back(i == 3);
      end
      read_frame(1'b1);
    end
`endif

    tick(); tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_frame_buf_ring.md
TX_FRAME_BUF_RING -- requirements
Module: tx_frame_buf_ring

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be 32 or 64.
REQ-002 Parameter SLOT_DEPTH, default 256, words per frame slot; SHALL be a power of two.
REQ-003 Parameter NUM_SLOTS, default 4, number of frame slots; SHALL be a power of two, at least 2.
REQ-004 Derived widths: AW=log2(SLOT_DEPTH), SW=log2(NUM_SLOTS), LW=log2(SLOT_DEPTH*DATA_W/8)+1.
REQ-005 hclk  in  1  sole clock; all logic rising-edge.
REQ-006 hresetn  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  write wr_data at wr_addr of the current write slot.
REQ-008 wr_addr  in  AW  word offset within the write slot.
REQ-009 wr_data  in  DATA_W  write word.
REQ-010 wr_commit  in  1  one-cycle pulse; closes the write slot with byte length wr_len.
REQ-011 wr_len  in  LW  frame length in bytes, sampled on wr_commit.
REQ-012 wr_full  out  1  no free slot is available.
REQ-013 wr_slot  out  SW  index of the current write slot.
REQ-014 wr_err  out  1  one-cycle pulse when a commit is rejected.
REQ-015 frame_avail  out  1  at least one committed frame is pending.
REQ-016 frame_len  out  LW  byte length of the head frame; valid while frame_avail=1.
REQ-017 rd_en  in  1  request the next word of the head frame.
REQ-018 rd_data  out  DATA_W  read word.
REQ-019 rd_dv  out  1  rd_data is valid.
REQ-020 rd_last  out  1  qualifies rd_dv on the final word of the frame.
REQ-021 rd_done  in  1  one-cycle pulse; releases the head slot.
REQ-022 rd_par_err  out  1  parity error on rd_data; present only with TX_BUF_PARITY_EN.

Function
REQ-023 Storage SHALL be one NUM_SLOTS*SLOT_DEPTH x DATA_W synchronous RAM addressed as {slot, offset}.
REQ-024 The ring SHALL use a write pointer wp, a read pointer rp (both SW bits, wrapping modulo NUM_SLOTS) and an occupancy count cnt (0..NUM_SLOTS).
REQ-025 wr_slot SHALL equal wp; wr_full SHALL equal (cnt==NUM_SLOTS); frame_avail SHALL equal (cnt!=0).
REQ-026 A write when wr_full=1 SHALL be dropped, with no RAM change.
REQ-027 A commit with wr_full=1 or wr_len=0 or wr_len>SLOT_DEPTH*DATA_W/8 SHALL be rejected, pulse wr_err the next cycle and leave wp and cnt unchanged.
REQ-028 An accepted commit SHALL store wr_len in a per-slot length register, advance wp and increment cnt.
REQ-029 The read FSM SHALL have three states:
- IDLE: enters RD on frame_avail.
- RD: issues reads while rd_en=1; enters WAIT after the last word is issued.
- WAIT: waits for rd_done, then returns to IDLE.
REQ-030 In RD, a read word counter SHALL start at 0; each rd_en SHALL read {rp, counter}, and rd_dv SHALL assert exactly 1 cycle later.
REQ-031 The last word index SHALL be ceil(frame_len/(DATA_W/8))-1; rd_last SHALL accompany the rd_dv of that word.
REQ-032 rd_en in IDLE or WAIT, or with frame_avail=0, SHALL be ignored.
REQ-033 rd_done in any state with cnt!=0 SHALL advance rp, decrement cnt, clear the word counter and return the FSM to IDLE; rd_done with cnt=0 SHALL be ignored.
REQ-034 An accepted commit and rd_done in the same cycle SHALL leave cnt unchanged while moving both pointers.
REQ-035 The writer MAY write the slot at wp while frames in other slots are being read; a same-cycle write and read SHALL never target the same slot.

Reset
REQ-036 On hresetn=0, the following SHALL clear asynchronously: wp, rp, cnt, the word counter, all length registers and the FSM (to IDLE).
REQ-037 During reset: wr_full=0, wr_slot=0, wr_err=0, frame_avail=0, frame_len=0, rd_dv=0, rd_last=0, rd_par_err=0, rd_data=0.
REQ-038 RAM contents SHALL NOT be reset; a reset asserted mid-frame SHALL discard all pending frames.

Configuration
REQ-039 When macro TX_BUF_PARITY_EN is defined, each word SHALL store one extra even-parity bit computed on write.
REQ-040 With TX_BUF_PARITY_EN, parity SHALL be rechecked on read, and rd_par_err SHALL pulse with rd_dv on mismatch.
REQ-041 Without TX_BUF_PARITY_EN, the RAM SHALL be DATA_W wide and the rd_par_err port SHALL be absent.

Verification
REQ-042 Default parameters: write words 0..15 = 0x1000_0000+i to slot 0, commit wr_len=64, hold rd_en -> 16 rd_dv words matching the written data, rd_last on word 15, frame_len=64.
REQ-043 Commit 4 frames without rd_done -> wr_full=1; a 5th commit -> wr_err pulse, cnt stays 4, wr_slot stays 0.
REQ-044 Commit wr_len=0 -> wr_err pulse, frame_avail unchanged.
REQ-045 With cnt=2, commit and rd_done in the same cycle -> cnt=2, rp and wp each advance by 1; after wrapping 3->0, the data read matches the data written.
REQ-046 Assert hresetn=0 at word 5 of a 16-word read -> all outputs at reset values immediately; frame_avail=0 after release.
REQ-047 With TX_BUF_PARITY_EN, force-flip one RAM bit of word 3 -> rd_par_err=1 with the word-3 rd_dv only.
